ysyx_22050133_ifu_fetch: RTL and testbench

Instruction fetch unit feeding the decode stage of the RV64 pipeline. Owns the architectural fetch PC, issues single-beat 4-byte AXI4 reads to the instruction memory port, and presents `{pc, inst}` to the IF/ID register over a valid/ready handshake. Accepts branch/jump/trap redirects from execute and squashes any wrong-path fetch in flight.

---
 rtl/ysyx_22050133_ifu_fetch_pkg.sv | 22 ++
 rtl/ysyx_22050133_ifu_fetch.sv | 133 +++++++++++++
 tb/tb_ysyx_22050133_ifu_fetch.sv | 481 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_ifu_fetch_pkg.sv
// Shared AXI codes, fetch FSM encodings and reset PC for the fetch unit.
package ysyx_22050133_ifu_fetch_pkg;

    localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_OUT
    } fetch_state_e;

    function automatic logic [63:0] align4(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050133_ifu_fetch.sv
// Instruction fetch: owns the fetch PC, issues single-beat AXI reads and
// hands {pc, inst} to IF/ID; redirects squash any wrong-path fetch.
module ysyx_22050133_ifu_fetch
    import ysyx_22050133_ifu_fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          ID_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en,
    input  logic [63:0]     jump_pc,
    input  logic            inst_ready,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [63:0]     pc,
    output logic            inst_fault,
    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [ID_W-1:0] arid,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    input  logic            rvalid,
    output logic            rready,
    input  logic [63:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic [ID_W-1:0] rid
);

    fetch_state_e state, state_n;

    logic [63:0] fetch_pc, fetch_pc_n;
    logic        discard, discard_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] inst_q, inst_n;
    logic [63:0] pc_q, pc_n;
    logic        fault_q, fault_n;
    logic [63:0] jump_tgt;

    // Single outstanding read with a fixed ID: rid/rlast carry no information.
    logic unused_ok;
    assign unused_ok = ^{rlast, rid};

    assign jump_tgt = align4(jump_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= PC_RESET;
            discard  <= 1'b0;
            addr_q   <= '0;
            inst_q   <= '0;
            pc_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            discard  <= discard_n;
            addr_q   <= addr_n;
            inst_q   <= inst_n;
            pc_q     <= pc_n;
            fault_q  <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        discard_n  = discard;
        addr_n     = addr_q;
        inst_n     = inst_q;
        pc_n       = pc_q;
        fault_n    = fault_q;
        unique case (state)
            S_IDLE: begin
                state_n = S_AR;
                if (jump_en) fetch_pc_n = jump_tgt;
            end
            S_AR: begin
                // The address on the bus must stay put; remember to drop the beat.
                if (jump_en) begin
                    discard_n  = 1'b1;
                    fetch_pc_n = jump_tgt;
                end
                if (arready) state_n = S_AR == S_AR ? S_R : S_R;
            end
            S_R: begin
                if (jump_en) begin
                    discard_n  = 1'b1;
                    fetch_pc_n = jump_tgt;
                end
                if (rvalid) begin
                    if (discard || jump_en) begin
                        discard_n = 1'b0;
                        state_n   = S_AR;
                    end else begin
                        inst_n  = addr_q[2] ? rdata[63:32] : rdata[31:0];
                        pc_n    = fetch_pc;
                        fault_n = (rresp != AXI_RESP_OKAY);
                        state_n = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (jump_en) begin
                    fetch_pc_n = jump_tgt;
                    state_n    = S_AR;
                end else if (inst_ready) begin
                    fetch_pc_n = fetch_pc + 64'd4;
                    state_n    = S_AR;
                end
            end
        endcase
        // Capture the request address once on AR entry so it holds until arready.
        if (state_n == S_AR && state != S_AR) addr_n = fetch_pc_n[31:0];
    end

    assign arvalid    = (state == S_AR) && !rst;
    assign rready     = (state == S_R) && !rst;
    assign inst_valid = (state == S_OUT);
    assign araddr     = addr_q;
    assign arid       = '0;
    assign arlen      = 8'd0;
    assign arsize     = AXI_SIZE_BYTES_4;
    assign arburst    = AXI_BURST_INCR;
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_fault = fault_q;

endmodule

// File: tb/tb_ysyx_22050133_ifu_fetch.sv
// Bench for the fetch unit: AXI slave model plus an expected-output queue
// filled when each fetch is set up and drained when the DUT presents it.
module tb_ysyx_22050133_ifu_fetch;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [63:0] jump_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_fault;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    int vectors = 0;
    int miscompares = 0;

    exp_t        exp_q[$];
    logic [31:0] obs_ar[$];
    logic [31:0] err_addr;
    int          stall_left;
    int          r_delay;

    always #5 clk = ~clk;

    ysyx_22050133_ifu_fetch #(
        .PC_RESET(64'h0000_0000_8000_0000),
        .ID_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .jump_en   (jump_en),
        .jump_pc   (jump_pc),
        .inst_ready(inst_ready),
        .inst_valid(inst_valid),
        .inst      (inst),
        .pc        (pc),
        .inst_fault(inst_fault),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arid      (arid),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rid       (rid)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0013;
            32'h8000_0004: return 32'h0000_0093;
            default:       return a ^ 32'h1234_5000;
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a);
        exp_t e;
        e.pc    = {32'h0, a};
        e.inst  = word_at(a);
        e.fault = (a == err_addr);
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Handshakes are judged on pre-edge values; responses are driven #1 later.
    task automatic slave_loop();
        logic        ar_hs;
        logic        r_hs;
        logic [31:0] hs_addr;
        logic        pending;
        logic [31:0] paddr;
        int          cnt;
        pending = 1'b0;
        paddr   = '0;
        cnt     = 0;
        forever begin
            @(posedge clk);
            ar_hs   = arvalid && arready;
            r_hs    = rvalid && rready;
            hs_addr = araddr;
            #1;
            if (rst) begin
                arready = 1'b0;
                rvalid  = 1'b0;
                pending = 1'b0;
            end else begin
                if (r_hs) rvalid = 1'b0;
                if (ar_hs) begin
                    pending = 1'b1;
                    paddr   = hs_addr;
                    cnt     = r_delay;
                    obs_ar.push_back(hs_addr);
                end
                arready = 1'b0;
                if (arvalid && !pending && !rvalid) begin
                    if (stall_left > 0) stall_left--;
                    else arready = 1'b1;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        rvalid  = 1'b1;
                        rdata   = {word_at({paddr[31:3], 3'b100}),
                                   word_at({paddr[31:3], 3'b000})};
                        rresp   = (paddr == err_addr) ? 2'b10 : 2'b00;
                        pending = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (inst_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ar(output logic [31:0] a, output bit ok);
        ok = 1'b0;
        a  = '0;
        for (int i = 0; i < 40; i++) begin
            if (obs_ar.size() > 0) begin
                a  = obs_ar.pop_front();
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({arvalid, rready, inst_valid, inst_fault, inst, pc} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got av=%b rr=%b iv=%b f=%b inst=%h pc=%h exp all 0",
                     arvalid, rready, inst_valid, inst_fault, inst, pc);
        end
        vectors++;
        if ({arid, arlen, arsize, arburst} !== {4'h0, 8'h00, 3'b010, 2'b01}) begin
            miscompares++;
            $display("FAIL ar_consts got id=%h len=%h size=%b burst=%b exp 0/0/010/01",
                     arid, arlen, arsize, arburst);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        inst_ready = 1'b1;
        tick();
        vectors++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0000}) begin
            miscompares++;
            $display("FAIL first_ar got av=%b addr=%h exp 1 80000000", arvalid, araddr);
        end
        exp_q.push_back(mk_exp(32'h8000_0000));
        tick();
        vectors++;
        if ({rready, inst_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL first_r got rready=%b iv=%b exp 1 0", rready, inst_valid);
        end
        tick();
        e = exp_q.pop_front();
        vectors++;
        if ({inst_valid, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL lower_word got iv=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     inst_valid, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
        exp_q.push_back(mk_exp(32'h8000_0004));
        tick();
        vectors++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0004}) begin
            miscompares++;
            $display("FAIL second_ar got av=%b addr=%h exp 1 80000004", arvalid, araddr);
        end
        tick();
        tick();
        e = exp_q.pop_front();
        vectors++;
        if ({inst_valid, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL upper_word got iv=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     inst_valid, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
        tick();
        inst_ready = 1'b0;
        obs_ar.delete();
    endtask

    task automatic test_fault();
        exp_t        e;
        bit          ok;
        logic [31:0] a;
        exp_q.push_back(mk_exp(32'h8000_0008));
        wait_ar(a, ok);
        vectors++;
        if (!ok || a !== 32'h8000_0008) begin
            miscompares++;
            $display("FAIL fault_ar got ok=%b addr=%h exp 80000008", ok, a);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        vectors++;
        if ({ok, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL fault_out got ok=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     ok, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        vectors++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_000C}) begin
            miscompares++;
            $display("FAIL fault_advance got av=%b addr=%h exp 1 8000000c", arvalid, araddr);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        int   bad;
        e = mk_exp(32'h8000_000C);
        exp_q.push_back(e);
        wait_valid(ok);
        e = exp_q.pop_front();
        vectors++;
        if ({ok, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL hold_first got ok=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     ok, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({inst_valid, arvalid, pc, inst, inst_fault} !== {2'b10, e}) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_stable got %0d unstable cycles exp 0", bad);
        end
        obs_ar.delete();
        stall_left = 3;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        vectors++;
        if ({arvalid, araddr} !== {1'b1, 32'h8000_0010}) begin
            miscompares++;
            $display("FAIL hold_release got av=%b addr=%h exp 1 80000010", arvalid, araddr);
        end
    endtask

    task automatic test_jump_ar();
        exp_t e;
        bit   ok;
        int   leaked;
        int   moved;
        logic [31:0] a0;
        logic [31:0] a1;
        jump_en = 1'b1;
        jump_pc = 64'h0000_0000_8000_0103;
        tick();
        jump_en = 1'b0;
        leaked  = 0;
        moved   = 0;
        for (int i = 0; i < 40 && obs_ar.size() < 2; i++) begin
            if (inst_valid) leaked++;
            if (obs_ar.size() == 0 && arvalid && araddr !== 32'h8000_0010) moved++;
            tick();
        end
        vectors++;
        if (leaked != 0 || moved != 0) begin
            miscompares++;
            $display("FAIL jump_ar_squash got leaked=%0d moved=%0d exp 0 0", leaked, moved);
        end
        a0 = (obs_ar.size() > 0) ? obs_ar.pop_front() : 32'hx;
        a1 = (obs_ar.size() > 0) ? obs_ar.pop_front() : 32'hx;
        vectors++;
        if ({a0, a1} !== {32'h8000_0010, 32'h8000_0100}) begin
            miscompares++;
            $display("FAIL jump_ar_addrs got %h %h exp 80000010 80000100", a0, a1);
        end
        exp_q.push_back(mk_exp(32'h8000_0100));
        wait_valid(ok);
        e = exp_q.pop_front();
        vectors++;
        if ({ok, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL jump_ar_out got ok=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     ok, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
    endtask

    task automatic test_jump_out();
        exp_t e;
        bit   ok;
        obs_ar.delete();
        inst_ready = 1'b1;
        jump_en    = 1'b1;
        jump_pc    = 64'h0000_0000_8000_0200;
        tick();
        inst_ready = 1'b0;
        jump_en    = 1'b0;
        vectors++;
        if ({inst_valid, arvalid, araddr} !== {2'b01, 32'h8000_0200}) begin
            miscompares++;
            $display("FAIL jump_out_ar got iv=%b av=%b addr=%h exp 0 1 80000200",
                     inst_valid, arvalid, araddr);
        end
        exp_q.push_back(mk_exp(32'h8000_0200));
        wait_valid(ok);
        e = exp_q.pop_front();
        vectors++;
        if ({ok, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL jump_out_out got ok=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     ok, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
    endtask

    task automatic test_jump_r();
        exp_t e;
        bit   ok;
        int   leaked;
        logic [31:0] a0;
        logic [31:0] a1;
        obs_ar.delete();
        r_delay    = 2;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        wait_rready(ok);
        jump_en = 1'b1;
        jump_pc = 64'h0000_0000_8000_0300;
        tick();
        jump_en = 1'b0;
        r_delay = 0;
        leaked  = 0;
        for (int i = 0; i < 40 && obs_ar.size() < 2; i++) begin
            if (inst_valid) leaked++;
            tick();
        end
        a0 = (obs_ar.size() > 0) ? obs_ar.pop_front() : 32'hx;
        a1 = (obs_ar.size() > 0) ? obs_ar.pop_front() : 32'hx;
        vectors++;
        if (!ok || leaked != 0 || {a0, a1} !== {32'h8000_0204, 32'h8000_0300}) begin
            miscompares++;
            $display("FAIL jump_r got ok=%b leaked=%0d addrs %h %h exp 1 0 80000204 80000300",
                     ok, leaked, a0, a1);
        end
        exp_q.push_back(mk_exp(32'h8000_0300));
        wait_valid(ok);
        e = exp_q.pop_front();
        vectors++;
        if ({ok, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL jump_r_out got ok=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     ok, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
    endtask

    task automatic test_reset_in_r();
        exp_t        e;
        bit          ok;
        logic [31:0] a;
        r_delay    = 3;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        wait_rready(ok);
        rst = 1'b1;
        tick();
        vectors++;
        if ({ok, rready, arvalid, inst_valid} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_in_r got ok=%b rr=%b av=%b iv=%b exp 1 0 0 0",
                     ok, rready, arvalid, inst_valid);
        end
        tick();
        rst     = 1'b0;
        r_delay = 0;
        obs_ar.delete();
        exp_q.push_back(mk_exp(32'h8000_0000));
        wait_ar(a, ok);
        vectors++;
        if (!ok || a !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL restart_ar got ok=%b addr=%h exp 80000000", ok, a);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        vectors++;
        if ({ok, pc, inst, inst_fault} !== {1'b1, e}) begin
            miscompares++;
            $display("FAIL restart_out got ok=%b pc=%h inst=%h f=%b exp 1 %h %h %b",
                     ok, pc, inst, inst_fault, e.pc, e.inst, e.fault);
        end
    endtask

    initial begin
        rst        = 1'b1;
        jump_en    = 1'b0;
        jump_pc    = '0;
        inst_ready = 1'b0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        rresp      = 2'b00;
        rlast      = 1'b1;
        rid        = '0;
        err_addr   = 32'h8000_0008;
        stall_left = 0;
        r_delay    = 0;
        fork
            slave_loop();
        join_none
        test_reset();
        test_basic();
        test_fault();
        test_hold();
        test_jump_ar();
        test_jump_out();
        test_jump_r();
        test_reset_in_r();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
